gp_writeback_scheduler: RTL and testbench
=========================================

GP_WRITEBACK_SCHEDULER -- requirements
Module: gp_writeback_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, default 5, register index width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have ports clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have ports rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports issue_valid in 1 / issue_idx in IDX_W / issue_ready out 1: decode claims a destination register.
REQ-006 SHALL have ports ex_valid in 1 / ex_idx in IDX_W / ex_data in DATA_W / ex_ready out 1: execute-stage writeback request.
REQ-007 SHALL have ports mem_valid in 1 / mem_idx in IDX_W / mem_data in DATA_W / mem_ready out 1: load-unit writeback request.
REQ-008 SHALL have ports rf_write_enable out 1 / rf_write_idx out IDX_W / rf_write_data out DATA_W: the register-file write port, all registered.
REQ-009 SHALL have ports rs1_idx, rs2_idx in IDX_W / rs1_busy, rs2_busy out 1: combinational scoreboard query.
REQ-010 SHALL have ports pending_count out IDX_W+1 (number of busy bits set) and orphan_error out 1 (sticky).

Function
REQ-011 SHALL hold a 2^IDX_W-bit busy scoreboard; bit 0 is hard-wired 0.
REQ-012 Issue handshake: issue_ready = !busy[issue_idx] || issue_idx==0; the transfer occurs on issue_valid && issue_ready and sets busy[issue_idx] at that edge (no effect for idx 0).
REQ-013 Writeback arbitration SHALL be round-robin between ex and mem using a 1-bit last_grant register; when both are valid, the requester not granted last wins; a lone valid requester always wins.
REQ-014 Exactly one of ex_ready/mem_ready SHALL be high per cycle, for the granted valid requester only; ready SHALL never be high without the corresponding valid.
REQ-015 A granted request SHALL appear on rf_write_* on the next cycle (latency 1); rf_write_enable is high for exactly one cycle per accepted request.
REQ-016 A request to idx 0 SHALL be accepted (ready high) but produce rf_write_enable=0 in the following cycle, and SHALL still update last_grant.
REQ-017 busy[rf_write_idx] SHALL clear at the edge on which rf_write_enable is high.
REQ-018 When a set (issue) and a clear (rf write) target the same index at the same edge, set SHALL win.
REQ-019 An accepted writeback whose index has busy=0 (excluding idx 0) SHALL still be written and SHALL set orphan_error, which holds until reset.
REQ-020 rs1_busy/rs2_busy SHALL reflect the current registered scoreboard, without bypass of same-cycle set or clear.
REQ-021 pending_count SHALL equal the popcount of the registered scoreboard; its maximum is 2^IDX_W-1.

Reset
REQ-022 On rst high, immediately and regardless of clk: busy all 0, last_grant=mem (so ex wins the first contention), rf_write_enable=0, rf_write_idx=0, rf_write_data=0, orphan_error=0, pending_count=0.
REQ-023 A request in flight during reset SHALL be discarded; ready outputs SHALL be 0 while rst is high.

Structure
REQ-024 Shared package SHALL hold IDX_W/DATA_W defaults and the requester encoding constants (GRANT_EX=0, GRANT_MEM=1).
REQ-025 One sub-module, gp_scoreboard (busy vector, set/clear, query, popcount), SHALL be instantiated; arbitration and the output register SHALL stay in the top module.

Verification
REQ-026 Issue idx 5, then ex writes idx 5 data 0xDEADBEEF -> rs1_busy(5)=1 after the issue, rf_write_enable=1 with idx 5 / 0xDEADBEEF one cycle after ex_ready, busy(5)=0 after that edge.
REQ-027 ex and mem both valid for 4 cycles (idx 3/4) after reset -> grants ex,mem,ex,mem; rf writes follow in the same order, each one cycle later.
REQ-028 Issue idx 7 while busy(7)=1 -> issue_ready=0 until the rf write to 7 clears it; an issue and a clear of idx 7 on the same edge -> busy(7)=1.
REQ-029 mem writes idx 0 data 0x1 -> mem_ready=1, no rf_write_enable, pending_count unchanged, orphan_error=0.
REQ-030 ex writes idx 9 while not busy -> write performed, orphan_error=1 and held; rst asserted mid-stream between edges -> all outputs reach their reset values immediately.

Source files
------------

// File: rtl/gp_writeback_scheduler_pkg.sv
// Shared definitions for the writeback scheduler slice.
// Holds the default register index/data widths and the 1-bit requester
// encoding used by the round-robin writeback arbiter.
package gp_writeback_scheduler_pkg;

    localparam int unsigned IDX_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;

    // Requester encoding stored in last_grant
    localparam logic GRANT_EX  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/gp_writeback_scheduler_scoreboard.sv
// Register busy scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_en / set_idx         mark a register busy (decode claim)
//   clr_en / clr_idx         clear a register's busy bit (register-file write)
//   rs1_idx/rs2_idx          query indices
//   rs1_busy/rs2_busy        registered busy state of the queried registers
//   busy                     full registered busy vector
//   pending_count            popcount of the busy vector
module gp_scoreboard
    import gp_writeback_scheduler_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [IDX_W-1:0]          set_idx,
    input  logic                      clr_en,
    input  logic [IDX_W-1:0]          clr_idx,
    input  logic [IDX_W-1:0]          rs1_idx,
    input  logic [IDX_W-1:0]          rs2_idx,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [(1 << IDX_W)-1:0]   busy,
    output logic [IDX_W:0]            pending_count
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] busy_next;

    // Next scoreboard: clear applied first so a same-index set wins; bit 0 never busy
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Queries see only the registered state, no same-cycle bypass
    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_count = pending_count + {{IDX_W{1'b0}}, busy[i]};
        end
    end

endmodule

// File: rtl/gp_writeback_scheduler.sv
// Writeback scheduler: tracks destination-register claims from decode and
// arbitrates execute/load-unit writebacks onto a single register-file port.
// Ports:
//   clk, rst                                 clock, asynchronous active-high reset
//   issue_valid/issue_idx/issue_ready        decode destination claim handshake
//   ex_valid/ex_idx/ex_data/ex_ready         execute-stage writeback request
//   mem_valid/mem_idx/mem_data/mem_ready     load-unit writeback request
//   rf_write_enable/idx/data                 registered register-file write port
//   rs1_idx/rs2_idx -> rs1_busy/rs2_busy     combinational scoreboard query
//   pending_count                            number of busy registers
//   orphan_error                             sticky: write to a non-busy register
module gp_writeback_scheduler
    import gp_writeback_scheduler_pkg::*;
#(
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [IDX_W-1:0]  issue_idx,
    output logic              issue_ready,
    input  logic              ex_valid,
    input  logic [IDX_W-1:0]  ex_idx,
    input  logic [DATA_W-1:0] ex_data,
    output logic              ex_ready,
    input  logic              mem_valid,
    input  logic [IDX_W-1:0]  mem_idx,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_write_enable,
    output logic [IDX_W-1:0]  rf_write_idx,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [IDX_W-1:0]  rs1_idx,
    input  logic [IDX_W-1:0]  rs2_idx,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [IDX_W:0]    pending_count,
    output logic              orphan_error
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  busy;
    logic              last_grant;
    logic              issue_fire;
    logic              accept;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;

    gp_scoreboard #(
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (issue_fire),
        .set_idx       (issue_idx),
        .clr_en        (rf_write_enable),
        .clr_idx       (rf_write_idx),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .busy          (busy),
        .pending_count (pending_count)
    );

    // Register 0 is never busy, so it can always be claimed
    assign issue_ready = !rst && (!busy[issue_idx] || (issue_idx == '0));
    assign issue_fire  = issue_valid && issue_ready;

    // Round-robin: on contention the requester not granted last wins
    always_comb begin
        ex_ready  = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            if (ex_valid && (!mem_valid || (last_grant == GRANT_MEM))) begin
                ex_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    assign accept   = ex_ready || mem_ready;
    assign sel_idx  = mem_ready ? mem_idx  : ex_idx;
    assign sel_data = mem_ready ? mem_data : ex_data;

    // Output register, grant history and sticky orphan detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant      <= GRANT_MEM;
            rf_write_enable <= 1'b0;
            rf_write_idx    <= '0;
            rf_write_data   <= '0;
            orphan_error    <= 1'b0;
        end else begin
            // Writes to register 0 are accepted but dropped
            rf_write_enable <= accept && (sel_idx != '0);
            if (accept) begin
                last_grant    <= mem_ready ? GRANT_MEM : GRANT_EX;
                rf_write_idx  <= sel_idx;
                rf_write_data <= sel_data;
                if ((sel_idx != '0) && !busy[sel_idx]) begin
                    orphan_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gp_writeback_scheduler.sv
// Directed self-checking bench for gp_writeback_scheduler.
module tb_gp_writeback_scheduler;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_idx;
    logic        issue_ready;
    logic        ex_valid;
    logic [4:0]  ex_idx;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        mem_valid;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [5:0]  pending_count;
    logic        orphan_error;

    int total = 0;
    int bad   = 0;

    gp_writeback_scheduler #(
        .IDX_W  (5),
        .DATA_W (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_idx       (issue_idx),
        .issue_ready     (issue_ready),
        .ex_valid        (ex_valid),
        .ex_idx          (ex_idx),
        .ex_data         (ex_data),
        .ex_ready        (ex_ready),
        .mem_valid       (mem_valid),
        .mem_idx         (mem_idx),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_idx    (rf_write_idx),
        .rf_write_data   (rf_write_data),
        .rs1_idx         (rs1_idx),
        .rs2_idx         (rs2_idx),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .pending_count   (pending_count),
        .orphan_error    (orphan_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_idx   = 5'd0;
        ex_valid    = 1'b0;
        ex_idx      = 5'd0;
        ex_data     = 32'd0;
        mem_valid   = 1'b0;
        mem_idx     = 5'd0;
        mem_data    = 32'd0;
        rs1_idx     = 5'd5;
        rs2_idx     = 5'd7;

        // Reset state
        #2;
        chk("rst_we", rf_write_enable === 1'b0);
        chk("rst_idx", rf_write_idx === 5'd0);
        chk("rst_data", rf_write_data === 32'd0);
        chk("rst_pending", pending_count === 6'd0);
        chk("rst_orphan", orphan_error === 1'b0);
        chk("rst_issue_ready", issue_ready === 1'b0);
        ex_valid = 1'b1;
        #1;
        chk("rst_ex_ready", ex_ready === 1'b0);
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention right after reset: ex, mem, ex, mem
        ex_valid  = 1'b1;
        ex_idx    = 5'd3;
        mem_valid = 1'b1;
        mem_idx   = 5'd4;
        for (int k = 0; k < 4; k++) begin
            ex_data  = 32'h100 + 32'(k);
            mem_data = 32'h200 + 32'(k);
            #1;
            chk("rr_ex_ready", ex_ready === ((k % 2) == 0));
            chk("rr_mem_ready", mem_ready === ((k % 2) == 1));
            tick();
            chk("rr_we", rf_write_enable === 1'b1);
            chk("rr_idx", rf_write_idx === (((k % 2) == 0) ? 5'd3 : 5'd4));
            chk("rr_data", rf_write_data === (((k % 2) == 0) ? (32'h100 + 32'(k)) : (32'h200 + 32'(k))));
        end
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("rr_we_done", rf_write_enable === 1'b0);
        chk("rr_orphan", orphan_error === 1'b1);
        chk("rr_pending", pending_count === 6'd0);

        rst = 1'b1;
        #1;
        chk("rst2_orphan", orphan_error === 1'b0);
        tick();
        rst = 1'b0;

        // Issue 5 then ex writes 5
        issue_valid = 1'b1;
        issue_idx   = 5'd5;
        #1;
        chk("i5_ready", issue_ready === 1'b1);
        tick();
        issue_valid = 1'b0;
        chk("i5_busy", rs1_busy === 1'b1);
        chk("i5_pending", pending_count === 6'd1);
        ex_valid = 1'b1;
        ex_idx   = 5'd5;
        ex_data  = 32'hDEADBEEF;
        #1;
        chk("w5_ex_ready", ex_ready === 1'b1);
        chk("w5_mem_ready", mem_ready === 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("w5_we", rf_write_enable === 1'b1);
        chk("w5_idx", rf_write_idx === 5'd5);
        chk("w5_data", rf_write_data === 32'hDEADBEEF);
        chk("w5_busy_still", rs1_busy === 1'b1);
        tick();
        chk("w5_busy_clr", rs1_busy === 1'b0);
        chk("w5_we_off", rf_write_enable === 1'b0);
        chk("w5_pending", pending_count === 6'd0);
        chk("w5_orphan", orphan_error === 1'b0);

        // mem writes idx 0: accepted, dropped, still updates last_grant
        issue_valid = 1'b1;
        issue_idx   = 5'd2;
        tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1;
        mem_idx   = 5'd0;
        mem_data  = 32'h1;
        #1;
        chk("z_mem_ready", mem_ready === 1'b1);
        chk("z_ex_ready", ex_ready === 1'b0);
        tick();
        mem_valid = 1'b0;
        chk("z_we", rf_write_enable === 1'b0);
        chk("z_pending", pending_count === 6'd1);
        chk("z_orphan", orphan_error === 1'b0);
        ex_valid  = 1'b1;
        ex_idx    = 5'd2;
        mem_valid = 1'b1;
        mem_idx   = 5'd2;
        #1;
        chk("z_next_ex", ex_ready === 1'b1);
        chk("z_next_mem", mem_ready === 1'b0);
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
        #1;

        // Issue stall on busy 7, then same-edge set and clear
        issue_valid = 1'b1;
        issue_idx   = 5'd7;
        #1;
        chk("i7_ready", issue_ready === 1'b1);
        tick();
        chk("i7_busy", rs2_busy === 1'b1);
        chk("i7_stall", issue_ready === 1'b0);
        chk("i7_pending", pending_count === 6'd2);
        tick();
        chk("i7_stall2", issue_ready === 1'b0);
        chk("i7_pending2", pending_count === 6'd2);
        mem_valid = 1'b1;
        mem_idx   = 5'd7;
        mem_data  = 32'h77;
        #1;
        chk("w7_mem_ready", mem_ready === 1'b1);
        tick();
        mem_valid = 1'b0;
        chk("w7_we", rf_write_enable === 1'b1);
        chk("w7_idx", rf_write_idx === 5'd7);
        chk("w7_stall", issue_ready === 1'b0);
        tick();
        chk("w7_busy_clr", rs2_busy === 1'b0);
        chk("w7_ready", issue_ready === 1'b1);
        chk("w7_pending", pending_count === 6'd1);
        issue_valid = 1'b0;
        ex_valid = 1'b1;
        ex_idx   = 5'd7;
        ex_data  = 32'h700;
        #1;
        chk("s7_ex_ready", ex_ready === 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("s7_we", rf_write_enable === 1'b1);
        chk("s7_idx", rf_write_idx === 5'd7);
        chk("s7_busy0", rs2_busy === 1'b0);
        issue_valid = 1'b1;
        issue_idx   = 5'd7;
        #1;
        chk("s7_ready", issue_ready === 1'b1);
        tick();
        issue_valid = 1'b0;
        chk("s7_set_wins", rs2_busy === 1'b1);
        chk("s7_pending", pending_count === 6'd2);
        chk("s7_orphan", orphan_error === 1'b1);
        chk("s7_we_off", rf_write_enable === 1'b0);

        rst = 1'b1;
        #1;
        chk("rst3_pending", pending_count === 6'd0);
        tick();
        rst = 1'b0;

        // Orphan write to 9 and sticky hold
        ex_valid = 1'b1;
        ex_idx   = 5'd9;
        ex_data  = 32'h99;
        #1;
        chk("o9_ex_ready", ex_ready === 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("o9_we", rf_write_enable === 1'b1);
        chk("o9_idx", rf_write_idx === 5'd9);
        chk("o9_data", rf_write_data === 32'h99);
        chk("o9_orphan", orphan_error === 1'b1);
        tick();
        tick();
        chk("o9_orphan_hold", orphan_error === 1'b1);
        chk("o9_we_off", rf_write_enable === 1'b0);

        // Asynchronous reset mid-stream
        issue_valid = 1'b1;
        issue_idx   = 5'd6;
        ex_valid    = 1'b1;
        ex_idx      = 5'd9;
        ex_data     = 32'h55;
        tick();
        chk("ms_we", rf_write_enable === 1'b1);
        chk("ms_pending", pending_count === 6'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ms_rst_we", rf_write_enable === 1'b0);
        chk("ms_rst_idx", rf_write_idx === 5'd0);
        chk("ms_rst_data", rf_write_data === 32'd0);
        chk("ms_rst_orphan", orphan_error === 1'b0);
        chk("ms_rst_pending", pending_count === 6'd0);
        chk("ms_rst_ex_ready", ex_ready === 1'b0);
        chk("ms_rst_issue_ready", issue_ready === 1'b0);
        issue_valid = 1'b0;
        ex_valid    = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("ms_post_we", rf_write_enable === 1'b0);
        chk("ms_post_pending", pending_count === 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
